// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC register, single-outstanding imem fetch, one-entry decode buffer, redirect arbitration.
// Latency: instr_valid 1 cycle after imem_ready; backpressure via instr_ready holds the buffer. Optional: MISALIGN_TRAP_EN.
module fetch_sequencer #(
    parameter int                   OPD_WIDTH = 32,
    parameter int                   PC_WIDTH  = 12,
    parameter logic [OPD_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redir_csr,
    input  logic [OPD_WIDTH-1:0] csr_target,
    input  logic                 redir_br,
    input  logic [OPD_WIDTH-1:0] br_target,
    output logic                 imem_req,
    output logic [PC_WIDTH-1:0]  imem_addr,
    input  logic                 imem_ready,
    input  logic [31:0]          imem_rdata,
    output logic                 instr_valid,
    input  logic                 instr_ready,
    output logic [31:0]          instr_out,
    output logic [OPD_WIDTH-1:0] instr_pc,
`ifdef MISALIGN_TRAP_EN
    output logic                 misalign_exc,
    output logic [OPD_WIDTH-1:0] misalign_addr,
`endif
    output logic [OPD_WIDTH-1:0] pc_out
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_t;

    state_t                 state_q, state_d;
    logic [OPD_WIDTH-1:0]   pc_q, pc_d;
    logic                   valid_q, valid_d;
    logic [31:0]            instr_q, instr_d;
    logic [OPD_WIDTH-1:0]   ipc_q, ipc_d;
    logic [PC_WIDTH-1:0]    drop_addr_q, drop_addr_d;
    logic                   rst_dly_q;

    logic                   redir_any;
    logic                   redir_take;
    logic [OPD_WIDTH-1:0]   redir_tgt;
    logic [OPD_WIDTH-1:0]   redir_pc;

    always_comb begin
        redir_any = redir_csr | redir_br;
        redir_tgt = redir_csr ? csr_target : br_target;
`ifdef MISALIGN_TRAP_EN
        redir_take = redir_any && (redir_tgt[1:0] == 2'b00);
        redir_pc   = redir_tgt;
`else
        redir_take = redir_any;
        redir_pc   = redir_tgt & ~OPD_WIDTH'(3);
`endif
    end

`ifdef MISALIGN_TRAP_EN
    logic                 mexc_q;
    logic [OPD_WIDTH-1:0] maddr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mexc_q  <= 1'b0;
            maddr_q <= '0;
        end else begin
            mexc_q <= redir_any && !redir_take;
            if (redir_any && !redir_take) maddr_q <= redir_tgt;
        end
    end

    assign misalign_exc  = mexc_q;
    assign misalign_addr = maddr_q;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        ipc_d       = ipc_q;
        drop_addr_d = drop_addr_q;

        unique case (state_q)
            IDLE: if (!stall && !valid_q && !rst_dly_q) state_d = REQ;
            REQ: if (imem_ready) begin
                instr_d = imem_rdata;
                ipc_d   = pc_q;
                valid_d = 1'b1;
                pc_d    = pc_q + OPD_WIDTH'(4);
                state_d = HOLD;
            end
            HOLD: if (instr_ready) begin
                valid_d = 1'b0;
                state_d = stall ? IDLE : REQ;
            end
            DROP: if (imem_ready) state_d = REQ;
            default: state_d = IDLE;
        endcase

        // A taken redirect overrides the sequential update; an in-flight REQ keeps its address via DROP.
        if (redir_take) begin
            pc_d    = redir_pc;
            valid_d = 1'b0;
            instr_d = instr_q;
            ipc_d   = ipc_q;
            unique case (state_q)
                REQ: begin
                    state_d = imem_ready ? REQ : DROP;
                    drop_addr_d = pc_q[PC_WIDTH-1:0];
                end
                DROP: state_d = imem_ready ? REQ : DROP;
                default: state_d = (stall || rst_dly_q) ? IDLE : REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            valid_q     <= 1'b0;
            instr_q     <= '0;
            ipc_q       <= '0;
            drop_addr_q <= '0;
            rst_dly_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            ipc_q       <= ipc_d;
            drop_addr_q <= drop_addr_d;
            rst_dly_q   <= 1'b0;
        end
    end

    assign imem_req    = (state_q == REQ) || (state_q == DROP);
    assign imem_addr   = (state_q == DROP) ? drop_addr_q : pc_q[PC_WIDTH-1:0];
    assign instr_valid = valid_q;
    assign instr_out   = instr_q;
    assign instr_pc    = ipc_q;
    assign pc_out      = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: per-cycle vector table for sequential fetch, stalls and redirects,
// then hand-written sequences for PC wrap and reset in the middle of a fetch.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redir_csr = 1'b0;
    logic [31:0] csr_target = '0;
    logic        redir_br = 1'b0;
    logic [31:0] br_target = '0;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;
    logic [31:0] pc_out;
`ifdef MISALIGN_TRAP_EN
    logic        misalign_exc;
    logic [31:0] misalign_addr;
    localparam logic [31:0] T6 = 32'h84;
`else
    localparam logic [31:0] T6 = 32'h100;
`endif

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .stall(stall),
        .redir_csr(redir_csr), .csr_target(csr_target),
        .redir_br(redir_br), .br_target(br_target),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_out(instr_out), .instr_pc(instr_pc),
`ifdef MISALIGN_TRAP_EN
        .misalign_exc(misalign_exc), .misalign_addr(misalign_addr),
`endif
        .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall, rcsr, rbr, rdy, irdy;
        logic [31:0] ctgt, btgt, rdata;
        logic        e_req, e_vld, e_mexc;
        logic [11:0] e_addr;
        logic [31:0] e_instr, e_ipc, e_pc, e_maddr;
    } vec_t;

    vec_t        tv [0:63];
    int          nv = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] cur_maddr = '0;

    function automatic logic [31:0] rw(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic rdy, input logic irdy, input logic [31:0] rd,
                       input logic e_req, input logic [31:0] e_pc, input logic e_vld,
                       input logic [31:0] e_instr, input logic [31:0] e_ipc);
        tv[nv].stall = st;   tv[nv].rcsr = 1'b0; tv[nv].rbr = 1'b0;
        tv[nv].ctgt = '0;    tv[nv].btgt = '0;
        tv[nv].rdy = rdy;    tv[nv].irdy = irdy; tv[nv].rdata = rd;
        tv[nv].e_req = e_req; tv[nv].e_addr = e_pc[11:0]; tv[nv].e_pc = e_pc;
        tv[nv].e_vld = e_vld; tv[nv].e_instr = e_instr; tv[nv].e_ipc = e_ipc;
        tv[nv].e_mexc = 1'b0; tv[nv].e_maddr = cur_maddr;
        nv++;
    endtask

    initial begin
        // sequential fetch after reset: first request two cycles after rst falls
        add(0, 1, 1, 0, 0, 32'h0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 32'h0, 0, 0, 0);
        add(0, 1, 1, rw(32'h0), 1, 32'h0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 32'h4, 1, rw(32'h0), 32'h0);
        add(0, 1, 1, rw(32'h4), 1, 32'h4, 0, 0, 0);
        add(0, 1, 1, 0, 0, 32'h8, 1, rw(32'h4), 32'h4);
        add(0, 1, 1, rw(32'h8), 1, 32'h8, 0, 0, 0);
        add(0, 1, 1, 0, 0, 32'hC, 1, rw(32'h8), 32'h8);
        add(0, 1, 1, rw(32'hC), 1, 32'hC, 0, 0, 0);
        add(0, 1, 1, 0, 0, 32'h10, 1, rw(32'hC), 32'hC);
        // memory wait: address held for three cycles
        for (int i = 0; i < 3; i++) add(0, 0, 1, 32'hDEAD_BEEF, 1, 32'h10, 0, 0, 0);
        add(0, 1, 1, rw(32'h10), 1, 32'h10, 0, 0, 0);
        // decode backpressure for five cycles
        for (int i = 0; i < 5; i++) add(0, 1, 0, 0, 0, 32'h14, 1, rw(32'h10), 32'h10);
        add(0, 1, 1, 0, 0, 32'h14, 1, rw(32'h10), 32'h10);
        add(0, 1, 1, rw(32'h14), 1, 32'h14, 0, 0, 0);
        add(0, 1, 1, 0, 0, 32'h18, 1, rw(32'h14), 32'h14);
        add(0, 1, 1, rw(32'h18), 1, 32'h18, 0, 0, 0);
        add(0, 1, 1, 0, 0, 32'h1C, 1, rw(32'h18), 32'h18);
        add(0, 1, 1, rw(32'h1C), 1, 32'h1C, 0, 0, 0);
        add(0, 1, 1, 0, 0, 32'h20, 1, rw(32'h1C), 32'h1C);
        // branch while REQ at 0x20 is pending -> DROP, stale response discarded
        add(0, 0, 1, 0, 1, 32'h20, 0, 0, 0);
        tv[nv-1].rbr = 1'b1; tv[nv-1].btgt = 32'h100;
        add(0, 0, 1, 0, 1, 32'h100, 0, 0, 0);
        tv[nv-1].e_addr = 12'h020;
        add(0, 1, 1, 32'hBAD0_0020, 1, 32'h100, 0, 0, 0);
        tv[nv-1].e_addr = 12'h020;
        add(0, 1, 1, rw(32'h100), 1, 32'h100, 0, 0, 0);
        // CSR and branch together in HOLD: CSR target wins, buffer flushed
        add(0, 1, 0, 0, 0, 32'h104, 1, rw(32'h100), 32'h100);
        tv[nv-1].rcsr = 1'b1; tv[nv-1].ctgt = 32'h80;
        tv[nv-1].rbr = 1'b1;  tv[nv-1].btgt = 32'h100;
        add(0, 1, 1, rw(32'h80), 1, 32'h80, 0, 0, 0);
        // misaligned branch target
        add(0, 1, 1, 0, 0, 32'h84, 1, rw(32'h80), 32'h80);
        tv[nv-1].rbr = 1'b1; tv[nv-1].btgt = 32'h102;
`ifdef MISALIGN_TRAP_EN
        cur_maddr = 32'h102;
`endif
        add(0, 1, 1, rw(T6), 1, T6, 0, 0, 0);
`ifdef MISALIGN_TRAP_EN
        tv[nv-1].e_mexc = 1'b1;
`endif
        // stall in HOLD, in IDLE, and during an outstanding fetch
        add(1, 1, 1, 0, 0, T6 + 32'h4, 1, rw(T6), T6);
        add(1, 1, 1, 0, 0, T6 + 32'h4, 0, 0, 0);
        add(0, 1, 1, 0, 0, T6 + 32'h4, 0, 0, 0);
        add(1, 0, 1, 0, 1, T6 + 32'h4, 0, 0, 0);
        add(1, 1, 1, rw(T6 + 32'h4), 1, T6 + 32'h4, 0, 0, 0);
        add(0, 0, 1, 0, 0, T6 + 32'h8, 1, rw(T6 + 32'h4), T6 + 32'h4);

        // reset
        @(posedge clk);
        @(negedge clk);
        chk("rst imem_req", 32'(imem_req), 32'h0);
        chk("rst instr_valid", 32'(instr_valid), 32'h0);
        chk("rst instr_out", instr_out, 32'h0);
        chk("rst instr_pc", instr_pc, 32'h0);
        chk("rst pc_out", pc_out, 32'h0);
`ifdef MISALIGN_TRAP_EN
        chk("rst misalign_exc", 32'(misalign_exc), 32'h0);
        chk("rst misalign_addr", misalign_addr, 32'h0);
`endif
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < nv; i++) begin
            stall = tv[i].stall; redir_csr = tv[i].rcsr; csr_target = tv[i].ctgt;
            redir_br = tv[i].rbr; br_target = tv[i].btgt; imem_ready = tv[i].rdy;
            imem_rdata = tv[i].rdata; instr_ready = tv[i].irdy;
            @(negedge clk);
            chk($sformatf("v%0d imem_req", i), 32'(imem_req), 32'(tv[i].e_req));
            if (tv[i].e_req) chk($sformatf("v%0d imem_addr", i), 32'(imem_addr), 32'(tv[i].e_addr));
            chk($sformatf("v%0d instr_valid", i), 32'(instr_valid), 32'(tv[i].e_vld));
            if (tv[i].e_vld) begin
                chk($sformatf("v%0d instr_out", i), instr_out, tv[i].e_instr);
                chk($sformatf("v%0d instr_pc", i), instr_pc, tv[i].e_ipc);
            end
            chk($sformatf("v%0d pc_out", i), pc_out, tv[i].e_pc);
`ifdef MISALIGN_TRAP_EN
            chk($sformatf("v%0d misalign_exc", i), 32'(misalign_exc), 32'(tv[i].e_mexc));
            chk($sformatf("v%0d misalign_addr", i), misalign_addr, tv[i].e_maddr);
`endif
            @(posedge clk);
            #1;
        end

        // CSR redirect while REQ completes: response dropped, then wrap past 0xFFFFFFFC
        stall = 1'b0; redir_br = 1'b0;
        redir_csr = 1'b1; csr_target = 32'hFFFF_FFFC; imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
        @(posedge clk);
        #1 redir_csr = 1'b0; imem_rdata = 32'hC0DE_0001;
        @(negedge clk);
        chk("wrap imem_req", 32'(imem_req), 32'h1);
        chk("wrap imem_addr", 32'(imem_addr), 32'hFFC);
        chk("wrap pc_out", pc_out, 32'hFFFF_FFFC);
        chk("wrap flushed", 32'(instr_valid), 32'h0);
        @(posedge clk);
        #1 imem_ready = 1'b0; instr_ready = 1'b1;
        @(negedge clk);
        chk("wrap pc_out zero", pc_out, 32'h0);
        chk("wrap instr_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wrap instr_out", instr_out, 32'hC0DE_0001);
        chk("wrap instr_valid", 32'(instr_valid), 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk("wrap next addr", 32'(imem_addr), 32'h0);
        chk("wrap next req", 32'(imem_req), 32'h1);

        // reset in the middle of a fetch, with the response arriving in the reset cycle
        @(posedge clk);
        #1 rst = 1'b1; imem_ready = 1'b1; imem_rdata = 32'h0BAD_0BAD;
        @(posedge clk);
        #1 rst = 1'b0; imem_ready = 1'b1;
        @(negedge clk);
        chk("midrst imem_req", 32'(imem_req), 32'h0);
        chk("midrst instr_valid", 32'(instr_valid), 32'h0);
        chk("midrst instr_out", instr_out, 32'h0);
        chk("midrst pc_out", pc_out, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst req still low", 32'(imem_req), 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("midrst req rises", 32'(imem_req), 32'h1);
        chk("midrst addr", 32'(imem_addr), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
